// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl -- system-clock-domain SPI master for 32-bit full-duplex
// transfers to spi_slave. Mode: CPOL=0, MSB first, mosi changes on the sck
// rise, both ends sample on the sck fall.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   tx_valid/tx_ready  word handshake; tx_data is the word to send
//   rx_valid           one-cycle pulse when rx_data holds a new word
//   rx_data            last received word, held until the next one
//   busy               a frame is in progress (any state but IDLE)
//   sck, csn, mosi     registered SPI outputs
//   miso               SPI data in
//
// Optional build macro SPI_BURST_EN: when the 32nd fall coincides with
// tx_valid, the next word is taken without releasing csn.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        sck,
  output logic        csn,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(CS_IDLE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   tx_sr_q, tx_sr_d;
  logic [31:0]   rx_sr_q, rx_sr_d;
  logic [31:0]   rx_data_q, rx_data_d;
  logic          sck_q, sck_d;
  logic          csn_q, csn_d;
  logic          mosi_q, mosi_d;
  logic          tx_ready_q, tx_ready_d;
  logic          rx_valid_q, rx_valid_d;
  logic          busy_q, busy_d;
  logic          accept;

  assign accept = tx_valid && tx_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    sck_d      = sck_q;
    csn_d      = csn_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_sr_d   = tx_data;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          cnt_d     = '0;
          csn_d     = 1'b0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            mosi_d  = tx_sr_q[31];
            tx_sr_d = {tx_sr_q[30:0], 1'b0};
          end else begin
            sck_d     = 1'b0;
            rx_sr_d   = {rx_sr_q[30:0], miso};
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd31) begin
`ifdef SPI_BURST_EN
              // Chain the next word straight into SHIFT; the finished word
              // is published here because HOLD is skipped.
              if (accept) begin
                tx_sr_d    = tx_data;
                rx_data_d  = {rx_sr_q[30:0], miso};
                rx_valid_d = 1'b1;
                rx_sr_d    = '0;
                bit_cnt_d  = '0;
              end else begin
                state_d = HOLD;
              end
`else
              state_d = HOLD;
`endif
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d      = '0;
          csn_d      = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      GAP: begin
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    // Registered ready: high in IDLE from the cycle after entry, dropped on
    // the accept edge.
    tx_ready_d = (state_q == IDLE) && (state_d == IDLE);
`ifdef SPI_BURST_EN
    // Open the handshake for exactly the cycle that ends on the 32nd fall.
    if ((state_d == SHIFT) && sck_d && (bit_cnt_d == 6'd31) && (cnt_d == DIV_LAST))
      tx_ready_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign sck      = sck_q;
  assign csn      = csn_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a default-parameter instance talking
// to a behavioural echo slave, plus CLK_DIV=1 and CLK_DIV=5 instances whose
// sck/csn timing is measured.
module tb_spi_master_ctrl;

  logic clk;
  logic rst;
  logic slv_rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // main instance (defaults)
  logic        m_tx_valid, m_tx_ready, m_rx_valid, m_busy, m_sck, m_csn, m_mosi, m_miso;
  logic [31:0] m_tx_data, m_rx_data;
  // CLK_DIV=1 instance
  logic        a_tx_valid, a_tx_ready, a_rx_valid, a_busy, a_sck, a_csn, a_mosi, a_miso;
  logic [31:0] a_tx_data, a_rx_data;
  // CLK_DIV=5 instance
  logic        b_tx_valid, b_tx_ready, b_rx_valid, b_busy, b_sck, b_csn, b_mosi, b_miso;
  logic [31:0] b_tx_data, b_rx_data;

  spi_master_ctrl dut (
    .clk(clk), .rst(rst), .tx_valid(m_tx_valid), .tx_ready(m_tx_ready),
    .tx_data(m_tx_data), .rx_valid(m_rx_valid), .rx_data(m_rx_data),
    .busy(m_busy), .sck(m_sck), .csn(m_csn), .mosi(m_mosi), .miso(m_miso)
  );

  spi_master_ctrl #(.CLK_DIV(1)) dut_div1 (
    .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx_data(a_tx_data), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
    .busy(a_busy), .sck(a_sck), .csn(a_csn), .mosi(a_mosi), .miso(a_miso)
  );

  spi_master_ctrl #(.CLK_DIV(5), .CS_SETUP(3), .CS_HOLD(4), .CS_IDLE(2)) dut_div5 (
    .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_data(b_tx_data), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
    .busy(b_busy), .sck(b_sck), .csn(b_csn), .mosi(b_mosi), .miso(b_miso)
  );

  assign a_miso = 1'b0;
  assign b_miso = 1'b0;

  // Behavioural spi_slave: shifts out the previous complete word it received
  // (0xDEADBEEF after its own reset), changing so on the rise, sampling si on
  // the fall. A frame of other than 32 bits leaves the stored word unchanged.
  logic [31:0] last_word, so_sr, si_sr;
  int unsigned si_bits;

  initial m_miso = 1'b0;

  always @(negedge m_csn) begin
    so_sr   <= last_word;
    si_bits <= 0;
  end

  always @(posedge m_sck) begin
    if (!m_csn) begin
      m_miso <= so_sr[31];
      so_sr  <= {so_sr[30:0], 1'b0};
    end
  end

  always @(negedge m_sck) begin
    if (!m_csn) begin
      si_sr   <= {si_sr[30:0], m_mosi};
      si_bits <= si_bits + 1;
    end
  end

  always @(posedge m_csn or posedge slv_rst) begin
    if (slv_rst)           last_word <= 32'hDEADBEEF;
    else if (si_bits == 32) last_word <= si_sr;
  end

  // Main-instance event monitor, sampled on the falling clk edge.
  int unsigned m_rises = 0, m_falls = 0, m_frames = 0, m_rxp = 0, m_hi_run = 0;
  logic        mp_sck = 1'b0, mp_csn = 1'b1;
  logic [31:0] m_rxq[$];
  int unsigned m_gaps[$];

  always @(negedge clk) begin
    if (m_sck && !mp_sck && !m_csn) m_rises++;
    if (!m_sck && mp_sck && !m_csn) m_falls++;
    if (!m_csn && mp_csn) begin
      m_frames++;
      m_gaps.push_back(m_hi_run);
    end
    if (m_csn) m_hi_run++;
    else       m_hi_run = 0;
    if (m_rx_valid) begin
      m_rxp++;
      m_rxq.push_back(m_rx_data);
    end
    mp_sck = m_sck;
    mp_csn = m_csn;
  end

  // Timing monitor for the CLK_DIV=1 (index 0) and CLK_DIV=5 (index 1)
  // instances: sck phase lengths, csn-fall to first rise, last fall to csn rise.
  int unsigned since[2]     = '{0, 0};
  int unsigned pmin[2]      = '{255, 255};
  int unsigned pmax[2]      = '{0, 0};
  int unsigned setup_len[2] = '{0, 0};
  int unsigned hold_len[2]  = '{0, 0};
  logic        first_r[2]   = '{1'b0, 1'b0};
  logic        ps[2]        = '{1'b0, 1'b0};
  logic        pc[2]        = '{1'b1, 1'b1};
  logic        s_now[2], c_now[2];

  always @(negedge clk) begin
    s_now[0] = a_sck; c_now[0] = a_csn;
    s_now[1] = b_sck; c_now[1] = b_csn;
    for (int i = 0; i < 2; i++) begin
      since[i]++;
      if (!c_now[i] && pc[i]) begin
        since[i]   = 0;
        first_r[i] = 1'b1;
      end else if (s_now[i] && !ps[i] && !c_now[i]) begin
        if (first_r[i]) begin
          setup_len[i] = since[i];
          first_r[i]   = 1'b0;
        end else begin
          if (since[i] < pmin[i]) pmin[i] = since[i];
          if (since[i] > pmax[i]) pmax[i] = since[i];
        end
        since[i] = 0;
      end else if (!s_now[i] && ps[i] && !c_now[i]) begin
        if (since[i] < pmin[i]) pmin[i] = since[i];
        if (since[i] > pmax[i]) pmax[i] = since[i];
        since[i] = 0;
      end else if (c_now[i] && !pc[i]) begin
        hold_len[i] = since[i];
        since[i]    = 0;
      end
      ps[i] = s_now[i];
      pc[i] = c_now[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int idx);
    case (idx)
      0:       return a_tx_ready && !a_busy;
      1:       return b_tx_ready && !b_busy;
      default: return m_tx_ready && !m_busy;
    endcase
  endfunction

  task automatic set_tx(input int idx, input logic v, input logic [31:0] d);
    case (idx)
      0:       begin a_tx_valid = v; a_tx_data = d; end
      1:       begin b_tx_valid = v; b_tx_data = d; end
      default: begin m_tx_valid = v; m_tx_data = d; end
    endcase
  endtask

  // Waits (bounded) until the instance is idle and ready; lat counts clk
  // edges from the call.
  task automatic wait_idle(input int idx, input int unsigned limit, output int unsigned lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!rdy(idx) && lat < limit);
  endtask

  // One handshake (accepted on the next rising edge), then wait for idle.
  task automatic run_frame(input int idx, input logic [31:0] word,
                           input int unsigned limit, output int unsigned lat);
    @(negedge clk);
    set_tx(idx, 1'b1, word);
    @(posedge clk);
    #1;
    set_tx(idx, 1'b0, 32'h0);
    wait_idle(idx, limit, lat);
  endtask

  initial begin
    int unsigned lat, b_r, b_f, b_p, b_fr, n, guard;
    logic        rdy_neg;
    logic [31:0] words[3];

    rst = 1'b1;
    slv_rst = 1'b1;
    set_tx(0, 1'b0, 32'h0);
    set_tx(1, 1'b0, 32'h0);
    set_tx(2, 1'b0, 32'h0);
    #12;
    check("rst_sck",      {31'h0, m_sck},      32'h0);
    check("rst_csn",      {31'h0, m_csn},      32'h1);
    check("rst_mosi",     {31'h0, m_mosi},     32'h0);
    check("rst_tx_ready", {31'h0, m_tx_ready}, 32'h0);
    check("rst_rx_valid", {31'h0, m_rx_valid}, 32'h0);
    check("rst_rx_data",  m_rx_data,           32'h0);
    check("rst_busy",     {31'h0, m_busy},     32'h0);
    @(negedge clk);
    rst = 1'b0;
    slv_rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'h0, m_tx_ready}, 32'h1);

    // First frame: fresh slave answers 0xDEADBEEF.
    // Frame length = CS_SETUP + 64*CLK_DIV + CS_HOLD + CS_IDLE + 1 = 135.
    b_r = m_rises; b_p = m_rxp;
    run_frame(2, 32'h12345678, 400, lat);
    check("f1_latency", lat, 32'd135);
    check("f1_rises",   m_rises - b_r, 32'd32);
    check("f1_rx_puls", m_rxp - b_p, 32'd1);
    check("f1_rx_data", m_rx_data, 32'hDEADBEEF);
    check("f1_slv_got", last_word, 32'h12345678);

    // Second frame: slave echoes the previous word.
    b_r = m_rises; b_p = m_rxp;
    run_frame(2, 32'hA5A5A5A5, 400, lat);
    check("f2_rises",   m_rises - b_r, 32'd32);
    check("f2_rx_puls", m_rxp - b_p, 32'd1);
    check("f2_rx_data", m_rx_data, 32'h12345678);
    check("f2_slv_got", last_word, 32'hA5A5A5A5);

    // CLK_DIV=1 (setup 2, hold 2, idle 2): 2+64+2+2+1 = 71 cycles.
    // First rise follows SETUP plus one low half-period.
    run_frame(0, 32'h0F0F1234, 300, lat);
    check("d1_latency", lat, 32'd71);
    check("d1_ph_min",  pmin[0], 32'd1);
    check("d1_ph_max",  pmax[0], 32'd1);
    check("d1_setup",   setup_len[0], 32'd3);
    check("d1_hold",    hold_len[0], 32'd2);

    // CLK_DIV=5, setup 3, hold 4, idle 2: 3+320+4+2+1 = 330 cycles.
    run_frame(1, 32'h89ABCDEF, 800, lat);
    check("d5_latency", lat, 32'd330);
    check("d5_ph_min",  pmin[1], 32'd5);
    check("d5_ph_max",  pmax[1], 32'd5);
    check("d5_setup",   setup_len[1], 32'd8);
    check("d5_hold",    hold_len[1], 32'd4);

    // Fresh slave for the multi-word run.
    @(negedge clk);
    slv_rst = 1'b1;
    @(negedge clk);
    slv_rst = 1'b0;
    words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
    b_fr = m_frames; b_p = m_rxp; b_r = m_rises;
    m_rxq.delete();
    n = 0; guard = 0;
`ifndef SPI_BURST_EN
    while (n < 3 && guard < 2000) begin
      m_tx_valid = 1'b1;
      m_tx_data  = words[n];
      rdy_neg    = m_tx_ready;
      @(posedge clk);
      if (rdy_neg) n++;
      @(negedge clk);
      guard++;
    end
    m_tx_valid = 1'b0;
    wait_idle(2, 400, lat);
    check("b2b_accepted", n, 32'd3);
    check("b2b_frames",   m_frames - b_fr, 32'd3);
    check("b2b_rx_puls",  m_rxp - b_p, 32'd3);
    check("b2b_rx0", (m_rxq.size() > 0) ? m_rxq[0] : 32'hX, 32'hDEADBEEF);
    check("b2b_rx1", (m_rxq.size() > 1) ? m_rxq[1] : 32'hX, 32'h1);
    check("b2b_rx2", (m_rxq.size() > 2) ? m_rxq[2] : 32'hX, 32'h2);
    // csn stays high at least CS_IDLE cycles between frames.
    check("b2b_gap1", {31'h0, (m_gaps[m_gaps.size()-2] >= 2)}, 32'h1);
    check("b2b_gap2", {31'h0, (m_gaps[m_gaps.size()-1] >= 2)}, 32'h1);
`else
    while (n < 2 && guard < 2000) begin
      m_tx_valid = 1'b1;
      m_tx_data  = words[n];
      rdy_neg    = m_tx_ready;
      @(posedge clk);
      if (rdy_neg) n++;
      @(negedge clk);
      guard++;
    end
    m_tx_valid = 1'b0;
    wait_idle(2, 600, lat);
    check("burst_accepted", n, 32'd2);
    check("burst_frames",   m_frames - b_fr, 32'd1);
    check("burst_rises",    m_rises - b_r, 32'd64);
    check("burst_rx_puls",  m_rxp - b_p, 32'd2);
    check("burst_rx0", (m_rxq.size() > 0) ? m_rxq[0] : 32'hX, 32'hDEADBEEF);
`endif

    // Abort during bit 17: reset drops csn and sck at once, no rx pulse.
    @(negedge clk);
    slv_rst = 1'b1;
    @(negedge clk);
    slv_rst = 1'b0;
    b_r = m_rises; b_p = m_rxp;
    m_tx_valid = 1'b1;
    m_tx_data  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    m_tx_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (m_rises - b_r < 17 && guard < 400);
    check("abort_bit17", m_rises - b_r, 32'd17);
    rst = 1'b1;
    #1;
    check("abort_csn",  {31'h0, m_csn},  32'h1);
    check("abort_sck",  {31'h0, m_sck},  32'h0);
    check("abort_busy", {31'h0, m_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(2, 50, lat);
    repeat (10) @(negedge clk);
    check("abort_no_rx", m_rxp - b_p, 32'd0);
    check("abort_rxd",   m_rx_data, 32'h0);

    b_r = m_rises; b_p = m_rxp;
    run_frame(2, 32'h0BADC0DE, 400, lat);
    check("post_latency", lat, 32'd135);
    check("post_rises",   m_rises - b_r, 32'd32);
    check("post_rx_puls", m_rxp - b_p, 32'd1);
    check("post_rx_data", m_rx_data, 32'hDEADBEEF);
    check("post_slv_got", last_word, 32'h0BADC0DE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
